// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage (MEM/WB register, load extension, result select, regfile write port); WB_RETIRE_CNT_EN adds a 64-bit instret counter
module wb_stage #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_m,
  input  logic                     regwrite_m,
  input  logic [ADDRESS_WIDTH-1:0] rd_m,
  input  logic [1:0]               resultsrc_m,
  input  logic [2:0]               funct3_m,
  input  logic [DATA_WIDTH-1:0]    aluresult_m,
  input  logic [DATA_WIDTH-1:0]    readdata_m,
  input  logic [DATA_WIDTH-1:0]    pcplus4_m,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic                     we3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     valid_w,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]              instret,
`endif
  output logic [ADDRESS_WIDTH-1:0] rd_w
);
  logic                  regwrite_w;
  logic [1:0]            resultsrc_w;
  logic [2:0]            funct3_w;
  logic [DATA_WIDTH-1:0] aluresult_w;
  logic [DATA_WIDTH-1:0] readdata_w;
  logic [DATA_WIDTH-1:0] pcplus4_w;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w     <= 1'b0;
      regwrite_w  <= 1'b0;
      rd_w        <= '0;
      resultsrc_w <= '0;
      funct3_w    <= '0;
      aluresult_w <= '0;
      readdata_w  <= '0;
      pcplus4_w   <= '0;
    end else if (flush) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
    end else if (!stall) begin
      valid_w     <= valid_m;
      regwrite_w  <= regwrite_m;
      rd_w        <= rd_m;
      resultsrc_w <= resultsrc_m;
      funct3_w    <= funct3_m;
      aluresult_w <= aluresult_m;
      readdata_w  <= readdata_m;
      pcplus4_w   <= pcplus4_m;
    end
  end
  // Halfword lane uses only address bit 1; misaligned halves read the aligned half.
  always_comb begin
    load_byte = readdata_w[{aluresult_w[1:0], 3'b000} +: 8];
    load_half = readdata_w[{aluresult_w[1], 4'b0000} +: 16];
    load_data = funct3_w == 3'b000 ? {{(DATA_WIDTH-8){load_byte[7]}}, load_byte} :
                funct3_w == 3'b001 ? {{(DATA_WIDTH-16){load_half[15]}}, load_half} :
                funct3_w == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, load_byte} :
                funct3_w == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, load_half} :
                readdata_w;
    wd3 = resultsrc_w == 2'b01 ? load_data :
          resultsrc_w == 2'b10 ? pcplus4_w :
          aluresult_w;
  end
  assign ad3 = rd_w;
  assign we3 = valid_w & regwrite_w & (rd_w != '0);
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q;
  // A stalled instruction sits in W for several edges but retires only on the releasing one.
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else if (valid_w && !stall) instret_q <= instret_q + 64'd1;
  end
  assign instret = instret_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; expected W outputs queued at drive time, popped after each edge
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_m, regwrite_m;
  logic [4:0]  rd_m;
  logic [1:0]  resultsrc_m;
  logic [2:0]  funct3_m;
  logic [31:0] aluresult_m, readdata_m, pcplus4_m;
  logic [4:0]  ad3, rd_w;
  logic        we3, valid_w;
  logic [31:0] wd3;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif
  typedef struct packed {
    logic        vw;
    logic        we;
    logic        care;
    logic [4:0]  ad;
    logic [31:0] wd;
  } exp_t;
  exp_t q[$];
  exp_t last;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
    .regwrite_m(regwrite_m), .rd_m(rd_m), .resultsrc_m(resultsrc_m), .funct3_m(funct3_m),
    .aluresult_m(aluresult_m), .readdata_m(readdata_m), .pcplus4_m(pcplus4_m),
    .ad3(ad3), .we3(we3), .wd3(wd3), .valid_w(valid_w),
`ifdef WB_RETIRE_CNT_EN
    .instret(instret),
`endif
    .rd_w(rd_w)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] rs, input logic [2:0] f3,
                                       input logic [31:0] alu, input logic [31:0] rdat,
                                       input logic [31:0] pc);
    logic [31:0] b, h, ld;
    b = (rdat >> (8 * alu[1:0])) & 32'hFF;
    h = (rdat >> (alu[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  ld = b[7] ? (b | 32'hFFFF_FF00) : b;
      3'b001:  ld = h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  ld = b;
      3'b101:  ld = h;
      default: ld = rdat;
    endcase
    case (rs)
      2'b01:   return ld;
      2'b10:   return pc;
      default: return alu;
    endcase
  endfunction
  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_empty"}, 64'd1, 64'd0);
      return;
    end
    e = q.pop_front();
    chk({tag, "_valid"}, {63'd0, valid_w}, {63'd0, e.vw});
    chk({tag, "_we"}, {63'd0, we3}, {63'd0, e.we});
    if (e.care) begin
      chk({tag, "_ad"}, {59'd0, ad3}, {59'd0, e.ad});
      chk({tag, "_rdw"}, {59'd0, rd_w}, {59'd0, e.ad});
      chk({tag, "_wd"}, {32'd0, wd3}, {32'd0, e.wd});
    end
  endtask
  task automatic drive(input string tag, input bit s, input bit f, input bit v, input bit rw,
                       input logic [4:0] rd, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc);
    exp_t e;
    stall = s; flush = f; valid_m = v; regwrite_m = rw; rd_m = rd;
    resultsrc_m = rs; funct3_m = f3; aluresult_m = alu; readdata_m = rdat; pcplus4_m = pc;
    if (f) e = '{vw: 1'b0, we: 1'b0, care: 1'b0, ad: '0, wd: '0};
    else if (s) e = last;
    else e = '{vw: v, we: v & rw & (rd != 0), care: 1'b1, ad: rd, wd: model(rs, f3, alu, rdat, pc)};
    last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    last = '{vw: 1'b0, we: 1'b0, care: 1'b1, ad: '0, wd: '0};
    q.push_back(last);
    compare("reset");
  endtask
  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_m = 1'b1; regwrite_m = 1'b1; rd_m = 5'd3;
    resultsrc_m = 2'b00; funct3_m = 3'b000; aluresult_m = 32'hDEAD_BEEF;
    readdata_m = 32'hCAFE_F00D; pcplus4_m = 32'h40;
    @(negedge clk);
    do_reset(2);
    drive("alu",   0, 0, 1, 1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
    drive("x0",    0, 0, 1, 1, 5'd0, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
    drive("lb",    0, 0, 1, 1, 5'd6, 2'b01, 3'b000, 32'h0000_1001, 32'h8877_F6A5, 32'h0);
    drive("lbu",   0, 0, 1, 1, 5'd6, 2'b01, 3'b100, 32'h0000_1000, 32'h8877_F6A5, 32'h0);
    drive("lb3",   0, 0, 1, 1, 5'd6, 2'b01, 3'b000, 32'h0000_1003, 32'h8877_F6A5, 32'h0);
    drive("lh",    0, 0, 1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_1002, 32'h8877_F6A5, 32'h0);
    drive("lhu",   0, 0, 1, 1, 5'd6, 2'b01, 3'b101, 32'h0000_1002, 32'h8877_F6A5, 32'h0);
    drive("lh_mis",0, 0, 1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_1001, 32'h8877_F6A5, 32'h0);
    drive("lw",    0, 0, 1, 1, 5'd6, 2'b01, 3'b010, 32'h0000_1000, 32'h8877_F6A5, 32'h0);
    drive("f3_011",0, 0, 1, 1, 5'd6, 2'b01, 3'b011, 32'h0000_1001, 32'h8877_F6A5, 32'h0);
    drive("rs11",  0, 0, 1, 1, 5'd8, 2'b11, 3'b000, 32'h0000_0777, 32'h8877_F6A5, 32'h99);
    drive("jal",   0, 0, 1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0555, 32'h0, 32'h0000_0104);
    drive("norw",  0, 0, 1, 0, 5'd4, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0);
    drive("inval", 0, 0, 0, 1, 5'd4, 2'b00, 3'b000, 32'h0000_0043, 32'h0, 32'h0);
    drive("cap7",  0, 0, 1, 1, 5'd7, 2'b00, 3'b000, 32'h0000_000A, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive("stall", 1, 0, 1, 1, 5'd9, 2'b10, 3'b001, 32'h0000_0055, 32'h1111, 32'h2222);
    drive("stflush", 1, 1, 1, 1, 5'd9, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
    drive("fl_hold", 1, 0, 1, 1, 5'd10, 2'b00, 3'b000, 32'h0000_0066, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++)
      drive("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
            1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
    drive("pre_rst", 0, 0, 1, 1, 5'd12, 2'b00, 3'b000, 32'h0000_0ABC, 32'h0, 32'h0);
    do_reset(1);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_rst", instret, 64'd0);
    drive("r1",    0, 0, 1, 1, 5'd1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    drive("r2",    0, 0, 1, 1, 5'd2, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0);
    drive("r2st",  1, 0, 1, 1, 5'd3, 2'b00, 3'b000, 32'h3, 32'h0, 32'h0);
    drive("r2st",  1, 0, 1, 1, 5'd3, 2'b00, 3'b000, 32'h3, 32'h0, 32'h0);
    drive("r3",    0, 0, 1, 1, 5'd3, 2'b00, 3'b000, 32'h3, 32'h0, 32'h0);
    drive("bub",   0, 0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    drive("r4",    0, 0, 1, 1, 5'd4, 2'b00, 3'b000, 32'h4, 32'h0, 32'h0);
    drive("idle",  0, 0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    drive("idle",  0, 0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    chk("cnt4", instret, 64'd4);
    drive("r5",    0, 0, 1, 1, 5'd5, 2'b00, 3'b000, 32'h5, 32'h0, 32'h0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive("wrap",  0, 0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    chk("cnt_wrap", instret, 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined RV32I core.
- Registers MEM-stage results into the MEM/WB pipeline register and selects the result: ALU, extended load data or PC+4.
- Drives the register file write port (address, write enable, write data).
- Writer-side counterpart to the register file's read ports. The register file commits on the falling edge, so decode reads the value in the same W cycle.

Parameters:
- ADDRESS_WIDTH, 5, register address width; must match the register file write-address port.
- DATA_WIDTH, 32, datapath width; only 32 supported.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold MEM/WB register contents
- flush  in  1  insert bubble into W
- valid_m  in  1  M-stage instruction valid
- regwrite_m  in  1  instruction writes rd
- rd_m  in  ADDRESS_WIDTH  destination register
- resultsrc_m  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- funct3_m  in  3  load size/sign
- aluresult_m  in  DATA_WIDTH  ALU result / load address
- readdata_m  in  DATA_WIDTH  raw aligned word from data memory
- pcplus4_m  in  DATA_WIDTH  PC+4
- ad3  out  ADDRESS_WIDTH  register file write address
- we3  out  1  register file write enable
- wd3  out  DATA_WIDTH  register file write data
- valid_w  out  1  W-stage valid, for hazard unit
- rd_w  out  ADDRESS_WIDTH  W-stage rd, for forwarding

Behaviour:
- MEM/WB register updates on posedge clk. Priority: rst > flush > stall > capture.
- rst: every W register cleared, so valid_w=0, we3=0, ad3=0, rd_w=0, wd3=0.
- flush: valid_w and regwrite_w cleared; other fields don't-care. Flush wins over a simultaneous stall.
- stall (no flush): all W registers hold; the outputs repeat the same write, which is idempotent.
- Otherwise all *_m inputs are captured. Latency M->W is exactly 1 cycle.
- ad3 = rd_w.
- we3 = valid_w & regwrite_w & (rd_w != 0). Writes to x0 are always suppressed.
- wd3 is combinational from the W registers. resultsrc 00 -> aluresult_w; 01 -> extended load; 10 -> pcplus4_w; 11 -> aluresult_w.
- Load extension:
  - Byte lane = aluresult_w[1:0]; half lane = aluresult_w[1]. aluresult_w[0] is ignored for halfwords; no misalignment trap.
  - funct3 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other funct3: whole word.
- Data is little-endian: lane 0 = bits [7:0].
- Reset mid-stream: a pending W write is dropped; first post-reset cycle has we3=0.
- No combinational path from any *_m input to any output.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output instret, 64 bits.
  - Reset to 0.
  - Increments by 1 on each rising edge where valid_w=1 and stall=0, so a stalled instruction counts once.
  - Wraps at 2^64-1 to 0.
  - flush does not affect the counter value.
- Undefined: no port, no counter logic. All other behaviour identical.

Test Plan:
- Reset, then ALU write: rst=1 for 2 cycles -> we3=0, wd3=0. Then valid_m=1, regwrite_m=1, rd_m=5, resultsrc=00, aluresult_m=0x0000_1234 -> next cycle ad3=5, we3=1, wd3=0x0000_1234.
- x0 suppression: same as above with rd_m=0 -> we3=0, valid_w=1.
- Load extension, readdata_m=0x8877_F6A5:
  - LB, addr ..01 -> wd3=0xFFFF_FFF6.
  - LBU, addr ..00 -> 0x0000_00A5.
  - LH, addr ..10 -> 0xFFFF_8877.
  - LHU, addr ..10 -> 0x0000_8877.
  - LW -> 0x8877_F6A5.
- JAL result: resultsrc=10, pcplus4_m=0x0000_0104, rd_m=1 -> wd3=0x0000_0104, we3=1.
- Stall/flush priority:
  - Capture rd=7 value 0xA, then stall=1 for 3 cycles with new M inputs -> outputs hold rd=7, 0xA.
  - Then stall=1 and flush=1 together -> next cycle valid_w=0, we3=0.
- WB_RETIRE_CNT_EN: 4 valid instructions, one with 2 stall cycles, plus 1 bubble -> instret=4. Force counter to 2^64-1, retire one -> instret=0.
